// File: rtl/param_regfile.sv
// Flop-based multi-read-port register file with optional hardwired-zero top entry.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module param_regfile #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [NRD-1:0]             rd_en,
    input  logic [NRD-1:0][AW-1:0]     rd_addr,
    output logic [NRD-1:0][WIDTH-1:0]  rd_data,
    output logic [NRD-1:0]             rd_valid
);

    localparam logic [AW-1:0] ZADDR = AW'(DEPTH - 1);

    logic [WIDTH-1:0]           mem_q [DEPTH];
    logic [WIDTH-1:0]           mem_d [DEPTH];
    logic [NRD-1:0][WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [NRD-1:0]             rd_valid_q, rd_valid_d;
    logic                       wr_ok;

    always_comb begin
        wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == ZADDR));
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        for (int p = 0; p < NRD; p++) begin
            if (rd_en[p]) begin
                rd_valid_d[p] = 1'b1;
                // Zero register reads are forced so they never depend on its storage.
                if ((ZERO_REG != 0) && (rd_addr[p] == ZADDR)) begin
                    rd_data_d[p] = '0;
                end else begin
                    rd_data_d[p] = mem_q[rd_addr[p]];
                end
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (rd_addr[p] == wr_addr)) begin
                    rd_data_d[p] = wr_data;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_param_regfile.sv
// Scoreboard bench for param_regfile (default parameters); follows REGFILE_BYPASS_EN if defined.
module tb_param_regfile;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [63:0]      wr_data;
    logic [1:0]       rd_en;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][63:0] rd_data;
    logic [1:0]       rd_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]       v;
        logic [1:0][63:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model [32];
    logic [63:0] hold  [2];

    param_regfile dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    // Reference: architectural register contents plus per-port last-read value.
    task automatic cyc(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [63:0] wd, input logic [1:0] re,
                       input logic [4:0] ra0, input logic [4:0] ra1);
        exp_t        e;
        logic [4:0]  ra;
        logic [63:0] val;
        @(negedge clk);
        reset      = rst;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        rd_en      = re;
        rd_addr[0] = ra0;
        rd_addr[1] = ra1;
        e.v = rst ? 2'b00 : re;
        for (int p = 0; p < 2; p++) begin
            ra = (p == 0) ? ra0 : ra1;
            if (rst) begin
                hold[p] = 64'd0;
            end else if (re[p]) begin
                val = (ra == 5'd31) ? 64'd0 : model[ra];
`ifdef REGFILE_BYPASS_EN
                if (we && ra == wa && wa != 5'd31) val = wd;
`endif
                hold[p] = val;
            end
            e.d[p] = hold[p];
        end
        exp_q.push_back(e);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 64'd0;
        end else if (we && wa != 5'd31) begin
            model[wa] = wd;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (rd_valid !== e.v) begin
                    errors++;
                    $display("FAIL rd_valid at %0t: got %b expected %b", $time, rd_valid, e.v);
                end
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (rd_data[p] !== e.d[p]) begin
                        errors++;
                        $display("FAIL rd_data[%0d] at %0t: got %h expected %h",
                                 p, $time, rd_data[p], e.d[p]);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [4:0]  wa, ra0, ra1;
        logic [63:0] wd;
        for (int i = 0; i < 32; i++) model[i] = 64'hx;
        hold[0] = 64'hx;
        hold[1] = 64'hx;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;

        cyc(1, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 0, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 2'b11, 5'(i), 5'(31 - i));

        cyc(0, 1, 5, 64'hDEADBEEF_CAFEF00D, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 2'b11, 5, 5);
        cyc(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 2'b11, 31, 31);
        cyc(0, 1, 31, 64'h1234_5678, 2'b11, 31, 31);

        cyc(0, 1, 7, 64'h1, 2'b00, 0, 0);
        cyc(0, 1, 7, 64'h2, 2'b11, 7, 6);
        cyc(0, 0, 0, 0, 2'b11, 7, 7);

        cyc(0, 1, 9, 64'h1234, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 2'b11, 9, 9);
        cyc(0, 1, 9, 64'h5555, 2'b00, 9, 9);
        cyc(0, 0, 0, 0, 2'b00, 0, 0);

        cyc(0, 1, 3, 64'hAA, 2'b00, 0, 0);
        cyc(1, 1, 4, 64'hBB, 2'b11, 3, 4);
        cyc(0, 0, 0, 0, 2'b11, 3, 4);
        cyc(0, 1, 4, 64'hCC, 2'b01, 4, 0);
        cyc(0, 0, 0, 0, 2'b10, 0, 4);

        for (int n = 0; n < 400; n++) begin
            wa  = 5'($urandom_range(0, 31));
            wd  = {$urandom, $urandom};
            ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), wa, wd,
                2'($urandom_range(0, 3)), ra0, ra1);
        end

        cyc(0, 0, 0, 0, 2'b00, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
